// File: rtl/t30_stack_node.sv
// rtl/t30_stack_node.sv - LIFO stack-memory mesh node with round-robin push/pop arbitration
// Grants are registered into one-cycle in_ack/out_ready pulses; a port sits out the cycle after its pulse.
module t30_stack_node #(
  parameter int DATA_WIDTH = 11,
  parameter int DEPTH      = 15,
  parameter int NUM_PORTS  = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS-1:0]            in_ack,
  input  logic [NUM_PORTS-1:0]            out_req,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_ready,
  output logic [CNT_W-1:0]                count,
  output logic                            full,
  output logic                            empty
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_WIDTH-1:0]           mem_q [DEPTH];
  logic [CNT_W-1:0]                count_q, count_d, top_idx;
  logic [PW-1:0]                   push_ptr_q, pop_ptr_q;
  logic [NUM_PORTS-1:0]            in_ack_q, out_ready_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_q;
  logic [NUM_PORTS-1:0]            push_elig, pop_elig;
  logic                            push_found, pop_found, push_go, pop_go;
  logic [PW-1:0]                   push_sel, pop_sel;
  logic [DATA_WIDTH-1:0]           push_word;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] sel);
    return PW'((int'(sel) + 1) % NUM_PORTS);
  endfunction

  assign push_elig = in_ready & ~in_ack_q;
  assign pop_elig  = out_req & ~out_ready_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign top_idx   = count_q - CNT_W'(1);
  assign push_word = in_data[push_sel*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    push_found = 1'b0;
    push_sel   = '0;
    pop_found  = 1'b0;
    pop_sel    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!push_found && push_elig[(int'(push_ptr_q) + i) % NUM_PORTS]) begin
        push_found = 1'b1;
        push_sel   = PW'((int'(push_ptr_q) + i) % NUM_PORTS);
      end
      if (!pop_found && pop_elig[(int'(pop_ptr_q) + i) % NUM_PORTS]) begin
        pop_found = 1'b1;
        pop_sel   = PW'((int'(pop_ptr_q) + i) % NUM_PORTS);
      end
    end
  end

  // A pop in the same cycle frees the top slot, so a push is allowed even when full.
  assign pop_go  = pop_found && !flush && !empty;
  assign push_go = push_found && !flush && (!full || pop_go);

  always_comb begin
    count_d = count_q;
    if (flush)                count_d = '0;
    else if (push_go && !pop_go) count_d = count_q + CNT_W'(1);
    else if (pop_go && !push_go) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_go) mem_q[pop_go ? top_idx : count_q] <= push_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      push_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      in_ack_q    <= '0;
      out_ready_q <= '0;
      out_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      in_ack_q    <= '0;
      out_ready_q <= '0;
      if (pop_go) begin
        out_ready_q[pop_sel]                             <= 1'b1;
        out_data_q[pop_sel*DATA_WIDTH +: DATA_WIDTH]     <= mem_q[top_idx];
        pop_ptr_q                                        <= next_ptr(pop_sel);
      end
      if (push_go) begin
        in_ack_q[push_sel] <= 1'b1;
        push_ptr_q         <= next_ptr(push_sel);
      end
    end
  end

  assign in_ack    = in_ack_q;
  assign out_ready = out_ready_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
endmodule
